// File: rtl/elastic_fifo_if.sv
// rtl/elastic_fifo_if.sv - handshake, data and occupancy bundle for elastic_fifo
//
// Signals are named from the FIFO's point of view:
//   valid_i/ready_o/data_i  upstream side (producer -> FIFO)
//   valid_o/ready_i/data_o  downstream side (FIFO -> consumer)
//   count_o/full_o/empty_o  occupancy monitoring
// Modports:
//   slave   the FIFO itself
//   master  the environment driving the FIFO (producer + consumer)

interface elastic_fifo_if #(
    parameter int width_p = 8,
    parameter int depth_p = 8
);
    localparam int cnt_w = $clog2(depth_p + 1);

    logic               valid_i;
    logic               ready_o;
    logic [width_p-1:0] data_i;
    logic               valid_o;
    logic               ready_i;
    logic [width_p-1:0] data_o;
    logic [cnt_w-1:0]   count_o;
    logic               full_o;
    logic               empty_o;

    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, count_o, full_o, empty_o
    );

    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, count_o, full_o, empty_o
    );
endinterface

// File: rtl/elastic_fifo.sv
// rtl/elastic_fifo.sv - ready/valid elastic FIFO with wrap-bit pointers and occupancy
//
// Ports:
//   clk_i     clock, rising edge
//   reset_ni  asynchronous active-low reset (pointers and start-up flag only)
//   io        elastic_fifo_if.slave: valid_i/ready_o/data_i upstream,
//             valid_o/ready_i/data_o downstream, count_o/full_o/empty_o
// Parameters:
//   width_p   data width (>=1)
//   depth_p   entry count (power of two, >=2)
// Optional feature:
//   ELASTIC_FIFO_BYPASS_EN  when defined, an empty FIFO presents valid_i/data_i
//                           directly on valid_o/data_o (zero-latency pass-through)

module elastic_fifo #(
    parameter int width_p = 8,
    parameter int depth_p = 8
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    elastic_fifo_if.slave   io
);
    localparam int idx_w = $clog2(depth_p);
    localparam int ptr_w = idx_w + 1;
    localparam int cnt_w = $clog2(depth_p + 1);

    logic [ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    // Low during reset and until the first edge after release; holds ready_o low.
    logic               init_q, init_d;
    logic [width_p-1:0] mem_q [depth_p];
    logic [width_p-1:0] mem_d [depth_p];

    logic [idx_w-1:0]   wr_idx, rd_idx;
    logic               empty, full, ready, enq, deq;

    assign wr_idx = wr_ptr_q[idx_w-1:0];
    assign rd_idx = rd_ptr_q[idx_w-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_idx == rd_idx) && (wr_ptr_q[ptr_w-1] != rd_ptr_q[ptr_w-1]);
    // ready depends only on stored state, never on the consumer's ready_i.
    assign ready  = init_q & ~full;

`ifdef ELASTIC_FIFO_BYPASS_EN
    logic byp_hit;

    // Gated by init_q so nothing leaks through while in reset.
    assign byp_hit = empty & io.valid_i & init_q;

    always_comb begin
        io.valid_o = ~empty | byp_hit;
        io.data_o  = byp_hit ? io.data_i : mem_q[rd_idx];
        // A word taken straight through is never written into storage.
        enq        = io.valid_i & ready & ~(byp_hit & io.ready_i);
        deq        = io.ready_i & ~empty;
    end
`else
    always_comb begin
        io.valid_o = ~empty;
        io.data_o  = mem_q[rd_idx];
        enq        = io.valid_i & ready;
        deq        = io.ready_i & ~empty;
    end
`endif

    always_comb begin
        io.ready_o = ready;
        // Pointer difference is modulo 2*depth_p, so wrap never disturbs it.
        io.count_o = cnt_w'(wr_ptr_q - rd_ptr_q);
        io.full_o  = full;
        io.empty_o = empty;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        init_d   = 1'b1;
        mem_d    = mem_q;
        if (enq) begin
            wr_ptr_d       = wr_ptr_q + ptr_w'(1);
            mem_d[wr_idx]  = io.data_i;
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + ptr_w'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            init_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            init_q   <= init_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end
endmodule

// File: doc/elastic_fifo.md
# elastic_fifo

Ready/valid elastic FIFO that sits directly downstream of the delay buffer and absorbs its output bursts when the consumer stalls. It decouples the consumer's `ready_i` from the delay buffer's `ready_i`, breaking the combinational ready chain. It also exposes occupancy for flow monitoring. Storage is a register array with wrap-bit pointers; the output is read combinationally from the head entry.

## Interface
- `width_p`, default 8: data width in bits, ≥1.
- `depth_p`, default 8: entry count; power of two, ≥2.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_ni`  in  1  reset, asynchronous, active-low.
- `valid_i`  in  1  upstream data valid (from delay buffer `valid_o`).
- `ready_o`  out  1  FIFO can accept; feeds delay buffer `ready_i`.
- `data_i`  in  `width_p`  upstream data.
- `valid_o`  out  1  head entry valid toward consumer.
- `ready_i`  in  1  consumer accepts.
- `data_o`  out  `width_p`  head entry data.
- `count_o`  out  `$clog2(depth_p+1)`  current occupancy, 0..`depth_p`.
- `full_o`  out  1  `count_o == depth_p`.
- `empty_o`  out  1  `count_o == 0`.

## Operation
- Pointers `wr_ptr` and `rd_ptr` are each `$clog2(depth_p)+1` bits wide; the MSB is the wrap bit.
  - Empty when the pointers are equal.
  - Full when the index bits are equal and the wrap bits differ.
- Enqueue when `valid_i && ready_o`: write `data_i` to `mem[wr_ptr index]` and increment `wr_ptr`, wrapping modulo 2·`depth_p`.
- Dequeue when `valid_o && ready_i`: increment `rd_ptr`.
- `ready_o = ~full_o`. It never depends on `ready_i`; no combinational path runs from `ready_i` to `ready_o`.
- `valid_o = ~empty_o`, except under the bypass rule in Configuration.
- `data_o = mem[rd_ptr index]`. Its value is don't-care when `valid_o` is 0.
- Count updates:
  - Enqueue only: +1.
  - Dequeue only: −1.
  - Both, or neither: unchanged.
- Simultaneous enqueue and dequeue:
  - When full, enqueue is blocked (`ready_o` = 0), so only the dequeue occurs and count becomes `depth_p`−1.
  - When empty, only the enqueue occurs (dequeue requires `valid_o`), so count becomes 1. Bypass mode is the exception.
- Pointer wrap-around must not disturb `count_o`, `full_o` or `empty_o`.
- Holding stability: while `valid_o`=1 and `ready_i`=0, `data_o` and `valid_o` remain stable.
- Memory contents are not reset; only the pointers and count are reset.

## Timing
- While `reset_ni` is low, asynchronously and immediately:
  - Pointers are 0 and `count_o`=0.
  - `empty_o`=1, `full_o`=0, `valid_o`=0.
  - `ready_o` is forced to 0.
- First edge after `reset_ni` rises: `ready_o`=1.
- Reset asserted mid-operation discards all contents. Outputs take their reset values without waiting for a clock edge.
- Latency without bypass: an entry enqueued at edge N appears on `valid_o`/`data_o` after edge N, so the consumer can take it at edge N+1.
- Throughput: one transfer per cycle in each direction, sustained, at any occupancy between 1 and `depth_p`−1.
- `count_o`, `full_o` and `empty_o` are registered-state derived and update the cycle after the edge that changes them.

## Configuration
- Macro: `ELASTIC_FIFO_BYPASS_EN`.
- Defined: when the FIFO is empty and `valid_i`=1, the block presents the input directly:
  - `valid_o`=1 and `data_o`=`data_i` combinationally.
  - If `ready_i`=1 in that cycle, the word passes through with zero latency. No write occurs and count stays 0.
  - If `ready_i`=0, the word is enqueued normally.
  - `empty_o` still reflects stored occupancy only.
- Undefined: no combinational path from `valid_i`/`data_i` to the outputs. Minimum latency is one cycle, as in Timing.

## Test plan
- Reset: hold `reset_ni`=0 for 3 cycles, then release. Required: during reset `valid_o`=0, `ready_o`=0, `count_o`=0, `empty_o`=1; after the first edge `ready_o`=1.
- Fill and drain (`depth_p`=8): hold `ready_i`=0 and push 0x01..0x08. Required: `count_o` steps 1..8, `full_o`=1, `ready_o`=0; a 9th word (0x09) is not accepted. Then set `ready_i`=1. Required: outputs 0x01..0x08 in order on consecutive cycles, ending at `count_o`=0, `empty_o`=1.
- Full with simultaneous push and pop: when full, drive `valid_i`=1 with 0xAA and `ready_i`=1. Required: only the dequeue occurs and count becomes 7. The next cycle, 0xAA is enqueued while 0x02 dequeues, and count stays 7.
- Wrap-around: stream 40 words (0x00..0x27) with `ready_i` toggling 1,0,1,0. Required: exact in-order output with no loss or duplication, and `count_o` never exceeds 8 across pointer wraps.
- Bypass (with `ELASTIC_FIFO_BYPASS_EN`): while empty, drive `valid_i`=1, 0x5C, `ready_i`=1. Required: `data_o`=0x5C, `valid_o`=1 in the same cycle, and `count_o` stays 0. Without the macro: `valid_o`=0 in that cycle and 0x5C appears the next cycle with `count_o`=1.
- Reset mid-stream: at `count_o`=5, pulse `reset_ni` low between edges. Required: `valid_o`=0 and `count_o`=0 immediately, and old data never reappears after release.
